car_lane: RTL and testbench
===========================

Name: car_lane

Overview:
- Parametrised lane of traffic for the frog game grid.
- Moves NUM_CARS multi-cell cars along one row, with wrap-around and a level-scaled speed.
- Reports collisions with the frog.
- Sits between the game-state controller (enable, level, frog position) and the VGA renderer (car positions, occupancy); one instance per road row.

Parameters:
- GRID_W, 20, number of cells in the row; legal positions 0..GRID_W-1.
- X_W, 5, width of one position field; GRID_W <= 2**X_W is required.
- NUM_CARS, 3, cars per lane.
- CAR_LEN, 2, cells occupied per car; NUM_CARS*CAR_LEN <= GRID_W is required.
- SPEED_W, 24, prescaler counter width.
- BASE_PERIOD, 24'd6_000_000, clocks per step at level 0; must be >= 1.
- DIRECTION, 1, 1 = right (increasing x), 0 = left.
- START_X, 0, reset head position of car 0.
- SPACING, 7, reset distance between consecutive car heads; car k starts at (START_X + k*SPACING) mod GRID_W.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Enable  in  1  1 = lane runs; 0 = freeze (pause / game over)
- i_Level  in  3  speed level; step period = max(BASE_PERIOD >> i_Level, 1)
- i_Frog_X  in  X_W  frog column
- i_Frog_In_Lane  in  1  frog is on this row
- o_Car_X  out  NUM_CARS*X_W  packed head positions; car k in bits [k*X_W +: X_W]
- o_Tick  out  1  one-cycle pulse on the cycle the cars step
- o_Hit  out  1  registered collision flag
- o_Occupancy  out  GRID_W  occupied-cell bitmap (only with the optional feature)

Behaviour:
Reset (async assert, sync release):
- Car heads at their START/SPACING positions.
- Prescaler = BASE_PERIOD-1.
- o_Tick = 0, o_Hit = 0, o_Occupancy = footprint of the reset positions.

Prescaler (SPEED_W bits, down-counter):
- Holds while i_Enable = 0.
- When enabled and not 0: decrements.
- When enabled and at 0: reloads max(BASE_PERIOD >> i_Level, 1) - 1, asserts o_Tick for that cycle, and steps all cars.
- i_Level is sampled only at reload; a mid-count level change takes effect on the next period.
- At effective period 1, o_Tick stays high continuously and the cars step every cycle.

Step:
- DIRECTION = 1: head == GRID_W-1 -> 0, else head+1.
- DIRECTION = 0: head == 0 -> GRID_W-1, else head-1.
- All cars step on the same edge.
- o_Car_X is the position register itself: zero latency from the step edge, no stale extra-cycle copy.

Footprint:
- Car occupies its head plus CAR_LEN-1 trailing cells, opposite to the direction of travel, modulo GRID_W.
- Footprints straddling the wrap point are split across both ends of the row.

Hit:
- Comb term = i_Frog_In_Lane AND i_Frog_X inside any car footprint; registered into o_Hit, so o_Hit lags by 1 cycle.
- Evaluated every cycle regardless of i_Enable, so a frog that steps onto a frozen car is still reported.
- i_Frog_X >= GRID_W never hits.
- o_Hit is level, not sticky; the game controller latches it.

Overlapping cars (mis-set SPACING): legal; the occupancy bit is an OR; hit is asserted once.

Reset mid-period: the prescaler and positions return to reset values immediately; no tick is generated on release.

Optional Feature:
- Macro: CAR_LANE_OCCUPANCY_EN.
- Defined: o_Occupancy is present, a registered GRID_W bitmap of the union of footprints. It updates on the same edge as o_Car_X (computed from the next-state positions) and is used by the renderer instead of per-pixel comparisons.
- Undefined: the port and its logic are absent; the renderer decodes o_Car_X itself.

Decomposition:
- Package frog_game_pkg holds:
  - GRID_W_DEF = 20, X_W_DEF = 5
  - direction constants DIR_LEFT = 0, DIR_RIGHT = 1
  - the typedef for a grid coordinate (logic [X_W_DEF-1:0])
- Sub-module lane_tick_gen: the prescaler with level-scaled reload, enable and o_Tick.
- car_lane instantiates lane_tick_gen once, plus per-car position registers and footprint/hit logic in generate loops.

Test Plan:
- Reset, defaults, BASE_PERIOD=4, level 0, enabled -> o_Car_X = {14,7,0}; o_Tick every 4th cycle; after 20 ticks the positions return to {14,7,0}.
- DIRECTION=0, car head 0 at tick -> head becomes 19; footprint covers cells {19,0} at head 19 (trailing cell 0), and {0,1} when head 0.
- i_Enable low for 10 cycles mid-period -> o_Car_X and the prescaler frozen; the tick resumes with the remaining count intact.
- i_Level 0->2 mid-period with BASE_PERIOD=8 -> current period completes at 8; following periods are 2 cycles; i_Level=7 -> period 1, a step every cycle.
- Frog in lane, i_Frog_X = trailing cell of car 1 -> o_Hit = 1 exactly one cycle later; i_Frog_In_Lane=0 or i_Frog_X=25 -> o_Hit = 0.
- Assert i_Rst_L low asynchronously mid-period with CAR_LANE_OCCUPANCY_EN -> all outputs return to reset values before the next edge; o_Occupancy equals the reset footprint bitmap.

Source files
------------

// File: rtl/frog_game_pkg.sv
// Shared constants and types for the frog game grid.
package frog_game_pkg;

  localparam int GRID_W_DEF = 20;
  localparam int X_W_DEF    = 5;

  localparam bit DIR_LEFT  = 1'b0;
  localparam bit DIR_RIGHT = 1'b1;

  typedef logic [X_W_DEF-1:0] coord_t;

endpackage

// File: rtl/car_lane_tick_gen.sv
// lane_tick_gen: level-scaled step prescaler; o_Tick is high on the cycle the lane steps.
module lane_tick_gen #(
  parameter int                 SPEED_W     = 24,
  parameter logic [SPEED_W-1:0] BASE_PERIOD = 24'd6_000_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Enable,
  input  logic [2:0] i_Level,
  output logic       o_Tick
);

  logic [SPEED_W-1:0] count_q, count_d;
  logic [SPEED_W-1:0] scaled;
  logic [SPEED_W-1:0] reload;
  logic               tick;

  // Period is clamped to one clock, so a fully shifted-out base reloads zero.
  assign scaled = BASE_PERIOD >> i_Level;
  assign reload = (scaled == '0) ? '0 : scaled - SPEED_W'(1);
  assign tick   = i_Enable && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (tick) begin
      count_d = reload;
    end else if (i_Enable) begin
      count_d = count_q - SPEED_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count_q <= BASE_PERIOD - SPEED_W'(1);
    end else begin
      count_q <= count_d;
    end
  end

  assign o_Tick = tick;

endmodule

// File: rtl/car_lane.sv
// car_lane: one road row of wrapping multi-cell cars with frog collision detection.
// Optional registered occupancy bitmap output enabled by defining CAR_LANE_OCCUPANCY_EN.
module car_lane
  import frog_game_pkg::*;
#(
  parameter int                 GRID_W      = GRID_W_DEF,
  parameter int                 X_W         = X_W_DEF,
  parameter int                 NUM_CARS    = 3,
  parameter int                 CAR_LEN     = 2,
  parameter int                 SPEED_W     = 24,
  parameter logic [SPEED_W-1:0] BASE_PERIOD = 24'd6_000_000,
  parameter bit                 DIRECTION   = DIR_RIGHT,
  parameter int                 START_X     = 0,
  parameter int                 SPACING     = 7
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic                      i_Enable,
  input  logic [2:0]                i_Level,
  input  logic [X_W-1:0]            i_Frog_X,
  input  logic                      i_Frog_In_Lane,
  output logic [NUM_CARS*X_W-1:0]   o_Car_X,
  output logic                      o_Tick,
  output logic                      o_Hit
`ifdef CAR_LANE_OCCUPANCY_EN
  ,
  output logic [GRID_W-1:0]         o_Occupancy
`endif
);

  // Inputs to wrap_x stay within one row length of the legal range.
  function automatic logic [X_W-1:0] wrap_x(input int v);
    int w;
    w = v;
    if (w < 0) begin
      w = w + GRID_W;
    end else if (w >= GRID_W) begin
      w = w - GRID_W;
    end
    return X_W'(w);
  endfunction

  function automatic int to_int(input logic [X_W-1:0] x);
    return {{(32-X_W){1'b0}}, x};
  endfunction

  function automatic logic [X_W-1:0] next_x(input logic [X_W-1:0] h);
    return (DIRECTION == DIR_RIGHT) ? wrap_x(to_int(h) + 1) : wrap_x(to_int(h) - 1);
  endfunction

  // Cell j of a car trails its head, against the direction of travel.
  function automatic logic [X_W-1:0] trail(input logic [X_W-1:0] h, input int j);
    return (DIRECTION == DIR_RIGHT) ? wrap_x(to_int(h) - j) : wrap_x(to_int(h) + j);
  endfunction

  logic                tick;
  logic [NUM_CARS-1:0] car_hit;
  logic                hit_d, hit_q;

  lane_tick_gen #(
    .SPEED_W     (SPEED_W),
    .BASE_PERIOD (BASE_PERIOD)
  ) u_tick (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Enable (i_Enable),
    .i_Level  (i_Level),
    .o_Tick   (tick)
  );

`ifdef CAR_LANE_OCCUPANCY_EN
  function automatic logic [GRID_W-1:0] fp_mask(input logic [X_W-1:0] h);
    logic [GRID_W-1:0] m;
    m = '0;
    for (int j = 0; j < CAR_LEN; j++) begin
      m = m | ({{(GRID_W-1){1'b0}}, 1'b1} << trail(h, j));
    end
    return m;
  endfunction

  function automatic logic [GRID_W-1:0] reset_occ();
    logic [GRID_W-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_CARS; k++) begin
      m = m | fp_mask(wrap_x((START_X + k*SPACING) % GRID_W));
    end
    return m;
  endfunction

  logic [GRID_W-1:0] car_mask_d [NUM_CARS];
  logic [GRID_W-1:0] occ_d, occ_q;
`endif

  for (genvar k = 0; k < NUM_CARS; k++) begin : g_car
    localparam int             RST_I = (START_X + k*SPACING) % GRID_W;
    localparam logic [X_W-1:0] RST_X = X_W'(RST_I);

    logic [X_W-1:0]     pos_q, pos_d;
    logic [CAR_LEN-1:0] cell_hit;

    assign pos_d = tick ? next_x(pos_q) : pos_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        pos_q <= RST_X;
      end else begin
        pos_q <= pos_d;
      end
    end

    // Footprint cells are always < GRID_W, so an off-grid frog never matches.
    for (genvar j = 0; j < CAR_LEN; j++) begin : g_cell
      assign cell_hit[j] = (trail(pos_q, j) == i_Frog_X);
    end

    assign car_hit[k]              = |cell_hit;
    assign o_Car_X[k*X_W +: X_W]   = pos_q;
`ifdef CAR_LANE_OCCUPANCY_EN
    assign car_mask_d[k]           = fp_mask(pos_d);
`endif
  end

  assign hit_d = i_Frog_In_Lane && (|car_hit);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

`ifdef CAR_LANE_OCCUPANCY_EN
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < NUM_CARS; k++) begin
      occ_d = occ_d | car_mask_d[k];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      occ_q <= reset_occ();
    end else begin
      occ_q <= occ_d;
    end
  end

  assign o_Occupancy = occ_q;
`endif

  assign o_Tick = tick;
  assign o_Hit  = hit_q;

endmodule

// File: tb/tb_car_lane.sv
// Randomized scoreboard bench for car_lane: a right lane (period 4) and a left lane (period 8).
module tb_car_lane;
  import frog_game_pkg::*;

  localparam int G  = 20;
  localparam int XW = 5;
  localparam int NC = 3;
  localparam int CL = 2;
  localparam int SP = 7;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [2:0]    level;
  logic [XW-1:0] frog_x;
  logic          frog_in;

  logic [NC*XW-1:0] car_x_r, car_x_l;
  logic             tick_r, tick_l, hit_r, hit_l;
`ifdef CAR_LANE_OCCUPANCY_EN
  logic [G-1:0]     occ_r, occ_l;
`endif

  car_lane #(.BASE_PERIOD(24'd4), .DIRECTION(DIR_RIGHT)) dut_r (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_Enable       (en),
    .i_Level        (level),
    .i_Frog_X       (frog_x),
    .i_Frog_In_Lane (frog_in),
    .o_Car_X        (car_x_r),
    .o_Tick         (tick_r),
    .o_Hit          (hit_r)
`ifdef CAR_LANE_OCCUPANCY_EN
    ,
    .o_Occupancy    (occ_r)
`endif
  );

  car_lane #(.BASE_PERIOD(24'd8), .DIRECTION(DIR_LEFT)) dut_l (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_Enable       (en),
    .i_Level        (level),
    .i_Frog_X       (frog_x),
    .i_Frog_In_Lane (frog_in),
    .o_Car_X        (car_x_l),
    .o_Tick         (tick_l),
    .o_Hit          (hit_l)
`ifdef CAR_LANE_OCCUPANCY_EN
    ,
    .o_Occupancy    (occ_l)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Lane 0 moves right with base period 4, lane 1 moves left with base period 8.
  int heads [2][NC];
  int rem   [2];
  bit hit_m [2];

  function automatic int base_of(int ln);
    return (ln == 0) ? 4 : 8;
  endfunction

  function automatic bit right_of(int ln);
    return (ln == 0);
  endfunction

  function automatic int period(int ln, int lvl);
    int p;
    p = base_of(ln) >> lvl;
    return (p < 1) ? 1 : p;
  endfunction

  function automatic int step_x(int h, bit right);
    return right ? (h + 1) % G : (h + G - 1) % G;
  endfunction

  // Distance from the head measured against the travel direction.
  function automatic bit covers(int h, bit right, int x);
    int d;
    if (x >= G) return 1'b0;
    d = right ? (h - x + G) % G : (x - h + G) % G;
    return d < CL;
  endfunction

  function automatic bit lane_covers(int ln, int x);
    bit c;
    c = 1'b0;
    for (int k = 0; k < NC; k++) c = c | covers(heads[ln][k], right_of(ln), x);
    return c;
  endfunction

  task automatic model_reset();
    for (int ln = 0; ln < 2; ln++) begin
      for (int k = 0; k < NC; k++) heads[ln][k] = (k * SP) % G;
      rem[ln]   = base_of(ln) - 1;
      hit_m[ln] = 1'b0;
    end
  endtask

  // Advance the model across one clock edge using the inputs held before it.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int ln = 0; ln < 2; ln++) begin
      hit_m[ln] = frog_in && lane_covers(ln, int'(frog_x));
      if (en && rem[ln] == 0) begin
        for (int k = 0; k < NC; k++) heads[ln][k] = step_x(heads[ln][k], right_of(ln));
        rem[ln] = period(ln, int'(level)) - 1;
      end else if (en) begin
        rem[ln] = rem[ln] - 1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry layout: {occupancy[36:17], car_x[16:2], tick[1], hit[0]}
  logic [63:0] exp_r_q[$];
  logic [63:0] exp_l_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] expected(int ln);
    logic [63:0] v;
    logic [31:0] cx;
    logic [31:0] occ;
    cx  = '0;
    occ = '0;
    for (int k = 0; k < NC; k++) cx = cx | (32'(heads[ln][k]) << (k * XW));
    for (int x = 0; x < G; x++) if (lane_covers(ln, x)) occ = occ | (32'd1 << x);
    v = '0;
    v[36:17] = occ[19:0];
    v[16:2]  = cx[14:0];
    v[1]     = en && (rem[ln] == 0);
    v[0]     = hit_m[ln];
    return v;
  endfunction

  task automatic push_all();
    exp_r_q.push_back(expected(0));
    exp_l_q.push_back(expected(1));
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (exp_r_q.size() > 0) begin
      e = exp_r_q.pop_front();
      check("right.car_x", 32'(car_x_r), 32'(e[16:2]));
      check("right.tick",  32'(tick_r),  32'(e[1]));
      check("right.hit",   32'(hit_r),   32'(e[0]));
`ifdef CAR_LANE_OCCUPANCY_EN
      check("right.occupancy", 32'(occ_r), 32'(e[36:17]));
`endif
    end
    if (exp_l_q.size() > 0) begin
      e = exp_l_q.pop_front();
      check("left.car_x", 32'(car_x_l), 32'(e[16:2]));
      check("left.tick",  32'(tick_l),  32'(e[1]));
      check("left.hit",   32'(hit_l),   32'(e[0]));
`ifdef CAR_LANE_OCCUPANCY_EN
      check("left.occupancy", 32'(occ_l), 32'(e[36:17]));
`endif
    end
  end

  // ---------------- driver ----------------
  // Half the time the frog sits on a real footprint cell so hits actually occur.
  function automatic logic [XW-1:0] pick_frog();
    int ln, k, j, h;
    if ($urandom_range(0, 1) == 0) return XW'($urandom_range(0, 31));
    ln = $urandom_range(0, 1);
    k  = $urandom_range(0, NC - 1);
    j  = $urandom_range(0, CL - 1);
    h  = heads[ln][k];
    return right_of(ln) ? XW'((h - j + G) % G) : XW'((h + j) % G);
  endfunction

  task automatic drive_cycle(input bit n_rst, input bit n_en, input logic [2:0] n_lvl,
                             input logic [XW-1:0] fx, input bit fin);
    @(posedge clk);
    model_edge();
    #1;
    rst_n   = n_rst;
    en      = n_en;
    level   = n_lvl;
    frog_x  = fx;
    frog_in = fin;
    if (!n_rst) model_reset();
    push_all();
  endtask

  task automatic run_random(int n, bit n_en, logic [2:0] n_lvl);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, n_en, n_lvl, pick_frog(), $urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    level   = 3'd0;
    frog_x  = '0;
    frog_in = 1'b0;
    model_reset();

    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 3'd0, '0, 1'b0);

    // Level 0: right lane completes 20+ steps and wraps back to its start.
    run_random(100, 1'b1, 3'd0);

    // Freeze windows landing mid-period.
    for (int r = 0; r < 4; r++) begin
      run_random(3 + r, 1'b1, 3'd0);
      run_random(10, 1'b0, 3'd0);
    end

    // Level change mid-period, then maximum level (one step per cycle).
    run_random(3, 1'b1, 3'd0);
    run_random(30, 1'b1, 3'd2);
    run_random(25, 1'b1, 3'd7);

    // Off-grid frog and frog out of lane.
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1'b1, 3'd0, XW'(25), 1'b1);
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1'b1, 3'd0, pick_frog(), 1'b0);

    // Asynchronous reset asserted between edges, mid-period.
    run_random(5, 1'b1, 3'd0);
    drive_cycle(1'b0, 1'b1, 3'd0, pick_frog(), 1'b1);
    drive_cycle(1'b0, 1'b1, 3'd0, pick_frog(), 1'b1);
    run_random(20, 1'b1, 3'd0);

    // Fully random stretch with occasional resets, freezes and level changes.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        drive_cycle(1'b0, 1'b1, level, pick_frog(), 1'b1);
      end else begin
        drive_cycle(1'b1, $urandom_range(0, 9) != 0,
                    ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : level,
                    pick_frog(), $urandom_range(0, 3) != 0);
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
